// File: rtl/hmc_rf_responder_pkg.sv
// rtl/hmc_rf_responder_pkg.sv - shared FSM state type and register map for the HMC RF responder
package hmc_rf_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rf_state_e;

  localparam int unsigned ADDR_STATUS    = 0;
  localparam int unsigned ADDR_CONTROL   = 1;
  localparam int unsigned ADDR_EVENT_CNT = 2;
  localparam int unsigned ADDR_SCRATCH   = 3;

endpackage

// File: rtl/hmc_rf_responder_if.sv
// rtl/hmc_rf_responder_if.sv - register-file access bus between initiator (master) and responder (slave)
interface hmc_rf_responder_if #(
  parameter int HMC_RF_WWIDTH = 64,
  parameter int HMC_RF_RWIDTH = 64,
  parameter int HMC_RF_AWIDTH = 4
);
  logic [HMC_RF_AWIDTH-1:0] rf_address;
  logic [HMC_RF_WWIDTH-1:0] rf_write_data;
  logic                     rf_read_enable;
  logic                     rf_write_enable;
  logic [HMC_RF_RWIDTH-1:0] rf_read_data;
  logic                     rf_access_complete;
  logic                     rf_invalid_address;

  modport master (
    output rf_address, rf_write_data, rf_read_enable, rf_write_enable,
    input  rf_read_data, rf_access_complete, rf_invalid_address
  );

  modport slave (
    input  rf_address, rf_write_data, rf_read_enable, rf_write_enable,
    output rf_read_data, rf_access_complete, rf_invalid_address
  );
endinterface

// File: rtl/hmc_rf_event_counter.sv
// rtl/hmc_rf_event_counter.sv - wrapping event counter; a clear beats a same-cycle increment
module hmc_rf_event_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hmc_rf_responder.sv
// rtl/hmc_rf_responder.sv - RF target: STATUS/CONTROL/EVENT_CNT/SCRATCH, 2-cycle access latency
// EVENT_CNT exists only when HMC_RF_EVENT_CNT_EN is defined; otherwise address 0x2 is unmapped.
module hmc_rf_responder
  import hmc_rf_responder_pkg::*;
#(
  parameter int                 HMC_RF_WWIDTH = 64,
  parameter int                 HMC_RF_RWIDTH = 64,
  parameter int                 HMC_RF_AWIDTH = 4,
  parameter [HMC_RF_RWIDTH-1:0] CTRL_RST      = '0
) (
  input  logic                     clk,
  input  logic                     res_n,
  hmc_rf_responder_if.slave        rf,
  input  logic [31:0]              status_in,
  input  logic                     count_event,
  output logic [HMC_RF_RWIDTH-1:0] control_out
);

  localparam logic [HMC_RF_AWIDTH-1:0] A_STATUS    = HMC_RF_AWIDTH'(ADDR_STATUS);
  localparam logic [HMC_RF_AWIDTH-1:0] A_CONTROL   = HMC_RF_AWIDTH'(ADDR_CONTROL);
  localparam logic [HMC_RF_AWIDTH-1:0] A_EVENT_CNT = HMC_RF_AWIDTH'(ADDR_EVENT_CNT);
  localparam logic [HMC_RF_AWIDTH-1:0] A_SCRATCH   = HMC_RF_AWIDTH'(ADDR_SCRATCH);

  rf_state_e                state_q, state_d;
  logic [HMC_RF_AWIDTH-1:0] addr_q;
  logic [HMC_RF_WWIDTH-1:0] wdata_q;
  logic                     rd_q, wr_q;
  logic [HMC_RF_RWIDTH-1:0] scratch_q;
  logic [HMC_RF_RWIDTH-1:0] read_data_q;
  logic                     complete_q, invalid_q;

  logic                     latch_en, commit;
  logic                     readable, writable, access_ok;
  logic [HMC_RF_RWIDTH-1:0] rd_value;
  logic [HMC_RF_RWIDTH-1:0] wdata_ext;

  assign rf.rf_read_data       = read_data_q;
  assign rf.rf_access_complete = complete_q;
  assign rf.rf_invalid_address = invalid_q;
  assign wdata_ext             = HMC_RF_RWIDTH'(wdata_q);

`ifdef HMC_RF_EVENT_CNT_EN
  logic [HMC_RF_RWIDTH-1:0] evt_count;
  logic                     evt_clr;

  assign evt_clr = commit && access_ok && wr_q && (addr_q == A_EVENT_CNT);

  hmc_rf_event_counter #(
    .WIDTH (HMC_RF_RWIDTH)
  ) u_event_counter (
    .clk   (clk),
    .res_n (res_n),
    .inc   (count_event),
    .clr   (evt_clr),
    .count (evt_count)
  );
`else
  wire unused_count_event = count_event;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rf.rf_read_enable || rf.rf_write_enable) begin
          latch_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        commit  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode the latched request; simultaneous read+write is rejected regardless of address.
  always_comb begin
    readable = 1'b0;
    writable = 1'b0;
    rd_value = '0;
    case (addr_q)
      A_STATUS: begin
        readable = 1'b1;
        rd_value = HMC_RF_RWIDTH'(status_in);
      end
      A_CONTROL: begin
        readable = 1'b1;
        writable = 1'b1;
        rd_value = control_out;
      end
`ifdef HMC_RF_EVENT_CNT_EN
      A_EVENT_CNT: begin
        readable = 1'b1;
        writable = 1'b1;
        rd_value = evt_count;
      end
`endif
      A_SCRATCH: begin
        readable = 1'b1;
        writable = 1'b1;
        rd_value = scratch_q;
      end
      default: ;
    endcase
    access_ok = !(rd_q && wr_q) && (wr_q ? writable : readable);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      scratch_q   <= '0;
      control_out <= CTRL_RST;
      read_data_q <= '0;
      complete_q  <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      invalid_q  <= 1'b0;
      if (latch_en) begin
        addr_q  <= rf.rf_address;
        wdata_q <= rf.rf_write_data;
        rd_q    <= rf.rf_read_enable;
        wr_q    <= rf.rf_write_enable;
      end
      if (commit) begin
        complete_q <= 1'b1;
        invalid_q  <= !access_ok;
        if (!access_ok) begin
          read_data_q <= '0;
        end else if (rd_q) begin
          read_data_q <= rd_value;
        end else begin
          if (addr_q == A_CONTROL) control_out <= wdata_ext;
          if (addr_q == A_SCRATCH) scratch_q   <= wdata_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_hmc_rf_responder.sv
// tb/tb_hmc_rf_responder.sv - scoreboard bench for hmc_rf_responder (expectations follow HMC_RF_EVENT_CNT_EN)
module tb_hmc_rf_responder;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] status_in;
  logic        count_event;
  logic [63:0] control_out;
  logic [63:0] ctrl_at_done;

  logic        cnt_inc, cnt_clr;
  logic [3:0]  cnt_q;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        inv;
    logic        chk;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  logic prev_complete = 1'b0;

  always #5 clk = ~clk;

  hmc_rf_responder_if #(
    .HMC_RF_WWIDTH (64),
    .HMC_RF_RWIDTH (64),
    .HMC_RF_AWIDTH (4)
  ) rf_bus ();

  hmc_rf_responder #(
    .HMC_RF_WWIDTH (64),
    .HMC_RF_RWIDTH (64),
    .HMC_RF_AWIDTH (4),
    .CTRL_RST      (64'h0)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .rf          (rf_bus),
    .status_in   (status_in),
    .count_event (count_event),
    .control_out (control_out)
  );

  hmc_rf_event_counter #(.WIDTH(4)) u_wrap_cnt (
    .clk   (clk),
    .res_n (res_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (cnt_q)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rf_bus.rf_access_complete) begin
      check_eq("complete_single_cycle", {63'd0, prev_complete}, 64'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_completion", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("invalid_flag", {63'd0, rf_bus.rf_invalid_address}, {63'd0, e.inv});
        if (e.chk) check_eq("read_data", rf_bus.rf_read_data, e.data);
      end
    end else begin
      check_eq("invalid_needs_complete", {63'd0, rf_bus.rf_invalid_address}, 64'd0);
    end
    prev_complete <= rf_bus.rf_access_complete;
  end

  // Called at posedge+1; returns one idle cycle after the initiator drops the enables.
  task automatic do_access(input logic [3:0] a, input logic [63:0] d, input logic re, input logic we,
                           input logic exp_inv, input logic exp_chk, input logic [63:0] exp_data,
                           input logic ev_busy);
    sb.push_back('{inv: exp_inv, chk: exp_chk, data: exp_data});
    rf_bus.rf_address      = a;
    rf_bus.rf_write_data   = d;
    rf_bus.rf_read_enable  = re;
    rf_bus.rf_write_enable = we;
    @(posedge clk); #1;
    if (ev_busy) count_event = 1'b1;
    check_eq("no_early_complete", {63'd0, rf_bus.rf_access_complete}, 64'd0);
    @(posedge clk); #1;
    count_event  = 1'b0;
    ctrl_at_done = control_out;
    check_eq("latency_2", {63'd0, rf_bus.rf_access_complete}, 64'd1);
    @(posedge clk); #1;
    rf_bus.rf_read_enable  = 1'b0;
    rf_bus.rf_write_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_event(input int n);
    for (int i = 0; i < n; i++) begin
      count_event = 1'b1;
      @(posedge clk); #1;
      count_event = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_wrap(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_inc = 1'b1;
      @(posedge clk); #1;
    end
    cnt_inc = 1'b0;
  endtask

  logic [3:0]  b2b_addr [4] = '{4'h3, 4'h1, 4'h3, 4'h1};
  logic [63:0] b2b_data [4] = '{64'h1111, 64'h2222, 64'h0, 64'h0};
  logic        b2b_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] b2b_exp  [4] = '{64'h0, 64'h0, 64'h1111, 64'h2222};

  initial begin
    res_n                  = 1'b0;
    status_in              = 32'h0;
    count_event            = 1'b0;
    cnt_inc                = 1'b0;
    cnt_clr                = 1'b0;
    rf_bus.rf_address      = '0;
    rf_bus.rf_write_data   = '0;
    rf_bus.rf_read_enable  = 1'b0;
    rf_bus.rf_write_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    check_eq("rst_read_data", rf_bus.rf_read_data, 64'h0);
    check_eq("rst_complete", {63'd0, rf_bus.rf_access_complete}, 64'd0);
    check_eq("rst_control", control_out, 64'h0);
    @(posedge clk); #1;

    do_access(4'h1, 64'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    check_eq("control_at_complete", ctrl_at_done, 64'hDEAD_BEEF);
    do_access(4'h1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    check_eq("read_data_held", rf_bus.rf_read_data, 64'hDEAD_BEEF);

    status_in = 32'h1234_5678;
    do_access(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1234_5678, 1'b0);
    do_access(4'h0, 64'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0);
    do_access(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1234_5678, 1'b0);
    status_in = 32'hCAFE_F00D;
    do_access(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hCAFE_F00D, 1'b0);

    do_access(4'h3, 64'hFFFF_0000_1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    do_access(4'h3, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_1234_5678, 1'b0);
    do_access(4'h9, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0);
    do_access(4'h9, 64'h77, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0);
    do_access(4'h3, 64'h77, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0);
    do_access(4'h3, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_1234_5678, 1'b0);

`ifdef HMC_RF_EVENT_CNT_EN
    pulse_event(5);
    do_access(4'h2, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd5, 1'b0);
    do_access(4'h2, 64'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    do_access(4'h2, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0);
    pulse_event(1);
    do_access(4'h2, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0);
`else
    pulse_event(5);
    do_access(4'h2, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0);
    do_access(4'h2, 64'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 1'b1);
`endif

    pulse_wrap(15);
    check_eq("wrap_all_ones", {60'd0, cnt_q}, 64'd15);
    pulse_wrap(1);
    check_eq("wrap_to_zero", {60'd0, cnt_q}, 64'd0);
    pulse_wrap(3);
    cnt_inc = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    check_eq("clear_beats_inc", {60'd0, cnt_q}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      do_access(b2b_addr[i], b2b_data[i], !b2b_we[i], b2b_we[i], 1'b0, !b2b_we[i], b2b_exp[i], 1'b0);
    end

    rf_bus.rf_address      = 4'h3;
    rf_bus.rf_write_data   = 64'h55;
    rf_bus.rf_write_enable = 1'b1;
    @(posedge clk); #1;
    res_n = 1'b0;
    #1;
    check_eq("mid_rst_complete", {63'd0, rf_bus.rf_access_complete}, 64'd0);
    check_eq("mid_rst_read_data", rf_bus.rf_read_data, 64'h0);
    check_eq("mid_rst_control", control_out, 64'h0);
    @(posedge clk); #1;
    rf_bus.rf_write_enable = 1'b0;
    @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;
    do_access(4'h3, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
    do_access(4'h1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
